// File: rtl/afu_user_pkg.sv
// afu_user_pkg: shared constants, tile-size helper and FSM state type for the
// streaming transpose block.
package afu_user_pkg;

  localparam int LINE_WIDTH = 512;

  // Tile dimension: elements per cache line.
  function automatic int tile_dim(input int data_width);
    return LINE_WIDTH / data_width;
  endfunction

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
// Ports:
//   clk, reset     clock, async active-high reset
//   din, we        write data / push request (ignored while full)
//   re             pop request (ignored while empty)
//   dout           head line, loaded on a successful pop and held otherwise
//   full, empty    occupancy flags
//   count          lines currently held
module sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = we && !full;
  assign pop   = re && !empty;

  // Storage is not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/afu_user.sv
// afu_user: streaming N x N matrix transpose behind the AFU host interface.
// Lines enter an input FIFO, N of them fill a tile buffer (one row each), and
// the tile is written out column by column into an output FIFO.
// Ports:
//   clk, reset                 clock, async active-high reset
//   input_fifo_din/we          input line and push strobe
//   input_fifo_full            input FIFO at capacity
//   input_fifo_almost_full     input count >= FIFO_DEPTH-4
//   input_fifo_count           lines held in input FIFO
//   output_fifo_dout           registered output line
//   output_fifo_re             pop output FIFO
//   output_fifo_empty          output FIFO empty
//   output_fifo_almost_empty   output count <= 1
//   ctx_length                 total job lines (0 = unbounded stream)
module afu_user
  import afu_user_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LINE_WIDTH-1:0]         input_fifo_din,
  input  logic                          input_fifo_we,
  output logic                          input_fifo_full,
  output logic                          input_fifo_almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   input_fifo_count,
  output logic [LINE_WIDTH-1:0]         output_fifo_dout,
  input  logic                          output_fifo_re,
  output logic                          output_fifo_empty,
  output logic                          output_fifo_almost_empty,
  input  logic [31:0]                   ctx_length
);

  localparam int N  = tile_dim(DATA_WIDTH);
  localparam int RW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t                state;
  logic [RW:0]           req;            // rows requested from the input FIFO
  logic [RW-1:0]         row;            // next row to be written
  logic [RW-1:0]         col;            // next column to be emitted
  logic                  rd_pend;        // a popped line arrives this cycle
  logic [31:0]           lines_consumed;

  logic [LINE_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic [LINE_WIDTH-1:0] out_din;
  logic                  out_we;
  logic                  out_full;
  logic [AW:0]           out_count;

  logic [LINE_WIDTH-1:0] tile [N];

  logic job_done;
  logic pop_in;
  logic tile_we;
  logic fill;

  // Once the job's lines are consumed, stop popping; later lines stay queued.
  assign job_done = (ctx_length != '0) && (lines_consumed == ctx_length);
  assign pop_in   = (state == ST_LOAD) && !in_empty && (req < (RW+1)'(N)) && !job_done;
  assign tile_we  = (state == ST_LOAD) && rd_pend;
  // Job ended mid-tile with nothing in flight: pad the remaining rows.
  assign fill     = (state == ST_LOAD) && !rd_pend && job_done && (row != '0);
  assign out_we   = (state == ST_DRAIN) && !out_full;

  assign input_fifo_almost_full   = (input_fifo_count >= (AW+1)'(FIFO_DEPTH - 4));
  assign output_fifo_almost_empty = (out_count <= (AW+1)'(1));

  sync_fifo #(.WIDTH(LINE_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (input_fifo_din),
    .we    (input_fifo_we),
    .re    (pop_in),
    .dout  (in_dout),
    .full  (input_fifo_full),
    .empty (in_empty),
    .count (input_fifo_count)
  );

  sync_fifo #(.WIDTH(LINE_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (out_din),
    .we    (out_we),
    .re    (output_fifo_re),
    .dout  (output_fifo_dout),
    .full  (out_full),
    .empty (output_fifo_empty),
    .count (out_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_LOAD;
      req            <= '0;
      row            <= '0;
      col            <= '0;
      rd_pend        <= 1'b0;
      lines_consumed <= '0;
    end else begin
      rd_pend <= pop_in;
      if (pop_in) begin
        req            <= req + 1'b1;
        lines_consumed <= lines_consumed + 1'b1;
      end
      case (state)
        ST_LOAD: begin
          if (tile_we) begin
            row <= row + 1'b1;
            if (row == RW'(N - 1)) state <= ST_DRAIN;
          end else if (fill) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!out_full) begin
            if (col == RW'(N - 1)) begin
              col   <= '0;
              row   <= '0;
              req   <= '0;
              state <= ST_LOAD;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Tile storage needs no reset: every row is written or padded before a drain.
  always_ff @(posedge clk) begin
    if (tile_we) begin
      tile[row] <= in_dout;
    end else if (fill) begin
      for (int i = 0; i < N; i++)
        if (RW'(i) >= row) tile[i] <= '0;
    end
  end

  // Column col of the tile becomes one output line.
  always_comb begin
    out_din = '0;
    for (int i = 0; i < N; i++)
      out_din[i*DATA_WIDTH +: DATA_WIDTH] = tile[i][col*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_afu_user.sv
module tb_afu_user;

  localparam int DW    = 16;
  localparam int N     = 512 / DW;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] input_fifo_din = '0;
  logic         input_fifo_we = 1'b0;
  logic         input_fifo_full;
  logic         input_fifo_almost_full;
  logic [6:0]   input_fifo_count;
  logic [511:0] output_fifo_dout;
  logic         output_fifo_re = 1'b0;
  logic         output_fifo_empty;
  logic         output_fifo_almost_empty;
  logic [31:0]  ctx_length = '0;

  int checks = 0;
  int errors = 0;

  logic         rd_en = 1'b0;
  logic         prev_re = 1'b0;
  logic [511:0] got[$];
  logic [511:0] sent[$];
  logic [511:0] exp_q[$];

  afu_user #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .input_fifo_din           (input_fifo_din),
    .input_fifo_we            (input_fifo_we),
    .input_fifo_full          (input_fifo_full),
    .input_fifo_almost_full   (input_fifo_almost_full),
    .input_fifo_count         (input_fifo_count),
    .output_fifo_dout         (output_fifo_dout),
    .output_fifo_re           (output_fifo_re),
    .output_fifo_empty        (output_fifo_empty),
    .output_fifo_almost_empty (output_fifo_almost_empty),
    .ctx_length               (ctx_length)
  );

  always #5 clk = ~clk;

  // Host reader: pops whenever allowed, captures dout on the following negedge.
  always @(negedge clk) begin
    if (prev_re) got.push_back(output_fifo_dout);
    output_fifo_re = rd_en && !output_fifo_empty && !reset;
    prev_re = output_fifo_re;
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reference: transpose each group of N consumed lines; a trailing partial
  // group (only when the job is bounded) is padded with zero rows.
  function automatic void build_exp(input int ctx);
    int consumed, tiles, rows;
    logic [511:0] line;
    consumed = sent.size();
    if (ctx != 0 && ctx < consumed) consumed = ctx;
    tiles = (ctx != 0) ? (consumed + N - 1) / N : consumed / N;
    exp_q.delete();
    for (int t = 0; t < tiles; t++) begin
      rows = consumed - t * N;
      if (rows > N) rows = N;
      for (int j = 0; j < N; j++) begin
        line = '0;
        for (int i = 0; i < rows; i++) line[i*DW +: DW] = sent[t*N + i][j*DW +: DW];
        exp_q.push_back(line);
      end
    end
  endfunction

  task automatic do_reset(input logic [31:0] ctx);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    input_fifo_we = 1'b0;
    ctx_length = ctx;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got.delete();
    sent.delete();
  endtask

  // mode 0: random, 1: (k<<8)|c pattern, 2: all 0xFFFF
  task automatic push_seq(input int n, input bit chk_full, input int mode);
    logic [511:0] line;
    for (int k = 0; k < n; k++) begin
      case (mode)
        1: for (int c = 0; c < N; c++) line[c*DW +: DW] = 16'((k << 8) | c);
        2: line = '1;
        default: line = rand_line();
      endcase
      input_fifo_din = line;
      input_fifo_we  = 1'b1;
      if (chk_full) begin
        checks++;
        if (input_fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL push_not_full k=%0d: full=%b, want 0", k, input_fifo_full);
        end
      end
      sent.push_back(line);
      @(negedge clk);
    end
    input_fifo_we = 1'b0;
  endtask

  task automatic wait_lines(input int n, input int budget);
    int cyc = 0;
    rd_en = 1'b1;
    while (got.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctx_length = 32'd1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (output_fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", output_fifo_empty); end
    if (output_fifo_almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b want 1", output_fifo_almost_empty); end
    if (input_fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", input_fifo_full); end
    if (input_fifo_almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b want 0", input_fifo_almost_full); end
    if (input_fifo_count !== 7'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", input_fifo_count); end
    if (output_fifo_dout !== 512'd0) begin errors++; $display("FAIL rst_dout: got %h want 0", output_fifo_dout); end
    reset = 1'b0;
    // Job of one line: the other two stay queued, one padded tile is emitted.
    push_seq(3, 1'b0, 0);
    repeat (80) @(negedge clk);
    checks += 2;
    if (input_fifo_count !== 7'd2) begin errors++; $display("FAIL leftover_count: got %0d want 2", input_fifo_count); end
    if (output_fifo_empty !== 1'b0) begin errors++; $display("FAIL partial_emitted: empty=%b want 0", output_fifo_empty); end
    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (input_fifo_count !== 7'd0) begin errors++; $display("FAIL async_count: got %0d want 0", input_fifo_count); end
    if (output_fifo_empty !== 1'b1) begin errors++; $display("FAIL async_empty: got %b want 1", output_fifo_empty); end
    if (output_fifo_almost_empty !== 1'b1) begin errors++; $display("FAIL async_aempty: got %b want 1", output_fifo_almost_empty); end
    @(negedge clk);
  endtask

  task automatic test_one_tile();
    do_reset(32'd32);
    push_seq(N, 1'b1, 1);
    build_exp(32);
    wait_lines(exp_q.size(), 400);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL one_tile_lines: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL one_tile_line%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
    if (got.size() >= 2) begin
      checks += 2;
      if (got[1][15:0] !== 16'h0001) begin errors++; $display("FAIL one_tile_l1e0: got %h want 0001", got[1][15:0]); end
      if (got[0][31:16] !== 16'h0100) begin errors++; $display("FAIL one_tile_l0e1: got %h want 0100", got[0][31:16]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(32'd64);
    rd_en = 1'b1;
    push_seq(2 * N, 1'b1, 0);
    build_exp(64);
    wait_lines(exp_q.size(), 600);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_lines: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_line%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_partial();
    do_reset(32'd5);
    push_seq(5, 1'b1, 2);
    build_exp(5);
    wait_lines(exp_q.size(), 400);
    checks++;
    if (got.size() != N) begin errors++; $display("FAIL partial_lines: got %0d want %0d", got.size(), N); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks += 2;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL partial_line%0d: got %h want %h", k, got[k], exp_q[k]); end
      if (got[k][79:0] !== {80{1'b1}} || got[k][511:80] !== '0) begin
        errors++; $display("FAIL partial_shape%0d: got %h", k, got[k]);
      end
    end
  endtask

  task automatic test_backpressure_overflow();
    logic [511:0] line;
    do_reset(32'd160);
    push_seq(3 * N, 1'b1, 0);
    repeat (300) @(negedge clk);
    // Two tiles fill the output FIFO; the third is loaded and stalled.
    checks += 3;
    if (output_fifo_empty !== 1'b0) begin errors++; $display("FAIL bp_out_nonempty: got %b want 0", output_fifo_empty); end
    if (input_fifo_count !== 7'd0) begin errors++; $display("FAIL bp_in_drained: got %0d want 0", input_fifo_count); end
    if (input_fifo_full !== 1'b0) begin errors++; $display("FAIL bp_in_notfull: got %b want 0", input_fifo_full); end
    for (int k = 0; k < DEPTH; k++) begin
      line = rand_line();
      input_fifo_din = line;
      input_fifo_we  = 1'b1;
      sent.push_back(line);
      @(negedge clk);
      checks += 3;
      if (input_fifo_count !== 7'(k + 1)) begin errors++; $display("FAIL bp_count%0d: got %0d want %0d", k, input_fifo_count, k + 1); end
      if (input_fifo_almost_full !== (k + 1 >= DEPTH - 4)) begin errors++; $display("FAIL bp_afull%0d: got %b", k, input_fifo_almost_full); end
      if (input_fifo_full !== (k + 1 == DEPTH)) begin errors++; $display("FAIL bp_full%0d: got %b", k, input_fifo_full); end
    end
    // Overflow word: must be dropped.
    input_fifo_din = rand_line();
    input_fifo_we  = 1'b1;
    @(negedge clk);
    input_fifo_we  = 1'b0;
    checks += 2;
    if (input_fifo_count !== 7'd64) begin errors++; $display("FAIL ovf_count: got %0d want 64", input_fifo_count); end
    if (input_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", input_fifo_full); end
    build_exp(160);
    wait_lines(exp_q.size(), 2000);
    checks += 2;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_lines: got %0d want %0d", got.size(), exp_q.size());
    end
    if (output_fifo_empty !== 1'b1) begin errors++; $display("FAIL bp_final_empty: got %b want 1", output_fifo_empty); end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin errors++; $display("FAIL bp_line%0d: got %h want %h", k, got[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_one_tile();
    test_back_to_back();
    test_partial();
    test_backpressure_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afu_user.md
Name: afu_user

Overview:
- Streaming matrix-transpose accelerator user block behind the AFU host interface.
- Accepts 512-bit cache lines into an internal input FIFO and treats each group of N lines as an N x N tile of DATA_WIDTH-bit elements.
- Writes the transposed tile, N lines, into an internal output FIFO drained by the host side.

Parameters:
- DATA_WIDTH, 16, element width in bits; must divide 512.
- FIFO_DEPTH, 64, lines per internal FIFO; power of two and >= N.
- N (localparam), 512/DATA_WIDTH (32 at default), tile dimension.
- AW (localparam), log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- input_fifo_din  in  512  input line; element c is bits [c*DATA_WIDTH +: DATA_WIDTH].
- input_fifo_we  in  1  push din this cycle.
- input_fifo_full  out  1  input FIFO holds FIFO_DEPTH lines.
- input_fifo_almost_full  out  1  input count >= FIFO_DEPTH-4.
- input_fifo_count  out  AW+1  lines held in input FIFO.
- output_fifo_dout  out  512  output line, registered read data.
- output_fifo_re  in  1  pop output FIFO.
- output_fifo_empty  out  1  output FIFO holds 0 lines.
- output_fifo_almost_empty  out  1  output count <= 1.
- ctx_length  in  32  total input lines in the job; stable after reset release.

Behaviour:
- Reset (async, active-high): both FIFOs empty, all pointers and counts 0, FSM in LOAD, row and column counters 0, lines_consumed 0.
- Output values in reset:
  - full = 0, almost_full = 0, count = 0.
  - empty = 1, almost_empty = 1.
  - dout = 0.
- Reset asserted mid-tile discards all buffered data.
- Input FIFO:
  - Push when we=1 and not full.
  - we while full drops the word; count is unchanged.
  - Simultaneous push and pop leaves count unchanged.
- Output FIFO:
  - re with empty=0 presents the head line on dout the next cycle; dout holds its value otherwise.
  - re while empty is ignored.
- Tile buffer: N x N array of DATA_WIDTH-bit registers.
- Transpose rule: output line j, bits [i*DATA_WIDTH +: DATA_WIDTH] = element j of input line i of the same tile.
- FSM LOAD:
  - Each cycle the input FIFO is non-empty and fewer than N rows have been requested, pop one line.
  - Popped data returns one cycle later and is written to row r; r increments.
  - lines_consumed increments per pop.
  - When N rows are written, go to DRAIN.
- Early drain when the job ends mid-tile:
  - Trigger: ctx_length != 0, lines_consumed == ctx_length, 0 < r < N, no read in flight.
  - Rows r..N-1 are zero-filled, then go to DRAIN.
- FSM DRAIN:
  - Each cycle the output FIFO is not full, push column c as one line; c increments.
  - After column N-1 is pushed, clear r and c, then return to LOAD.
  - Pushing stalls while the output FIFO is full; no data is lost.
- LOAD does not overlap DRAIN (single buffer).
- Throughput is about 2N+2 cycles per tile.
- Latency: first output line is pushed 2 cycles after the Nth row's pop; empty deasserts on the following edge.
- ctx_length = 0 means an unbounded stream; only full tiles are emitted.
- Lines pushed after lines_consumed reaches ctx_length remain in the FIFO, unconsumed, until reset.

Decomposition:
- Package afu_user_pkg: LINE_WIDTH=512 and a function computing N from DATA_WIDTH.
- Sub-module sync_fifo (width, depth):
  - Registered read data, full/empty/count flags.
  - Instantiated twice, for input and output.
- The transpose buffer and FSM stay in afu_user.

Test Plan:
- Reset: hold reset 3 cycles -> empty=1, almost_empty=1, full=0, count=0, dout=0; asserting reset asynchronously mid-cycle clears flags without waiting for a clock edge.
- One tile, ctx_length=32: line i element c = (i<<8)|c -> 32 output lines; line j element i = (i<<8)|j, e.g. line 1 element 0 = 0x0001, line 0 element 1 = 0x0100.
- Back-to-back tiles, ctx_length=64, write every cycle, host reads whenever empty=0:
  - 64 output lines; tile 2 is transposed independently.
  - No drops while full=0.
- Partial tile, ctx_length=5, five lines of all 0xFFFF -> 32 output lines, each with elements 0..4 = 0xFFFF and 5..31 = 0.
- Output backpressure: withhold re until 64 lines are queued -> full output FIFO stalls DRAIN; input full asserts at 64 queued, almost_full at 60; resuming re yields all lines in order.
- Overflow: we=1 with full=1 -> word dropped, count stays 64, subsequent output is unaffected.
